conv3x3_stream_pipeline: RTL and testbench
==========================================

Name: conv3x3_stream_pipeline

Overview:
Streaming 3x3 2-D convolution engine, the parametrised successor to the fixed 16-bit convolution pipeline in the image kernel path. It accepts raster-order pixels under a valid qualifier with arbitrary stalls and keeps two line buffers of programmable length. Coefficients come from a runtime-writable shadow bank committed at frame start. It emits clamped results only for fully-inside ("valid" mode) windows, with frame markers.

Parameters:
DATA_W, 16, unsigned pixel width (in and out).
COEF_W, 17, signed two's-complement coefficient width.
LINE_LEN, 4, pixels per image row; minimum 4.
NUM_ROWS, 4, rows per frame; minimum 3.
ACC_W, DATA_W+COEF_W+4, signed accumulator width; must hold 9 full-scale products without overflow.

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  asynchronous, active-low reset.
in_valid  in  1  in_data/in_sof qualifier; a pixel is accepted on each clk edge with in_valid=1.
in_sof  in  1  accepted pixel is row 0, col 0 of a new frame.
in_data  in  DATA_W  unsigned pixel.
coef_we  in  1  shadow coefficient write strobe.
coef_addr  in  4  coefficient index 0..8, raster order (3*i+j).
coef_data  in  COEF_W  signed coefficient.
out_valid  out  1  one-cycle result strobe.
out_data  out  DATA_W  clamped result.
out_sof  out  1  with out_valid: first result of frame.
out_eof  out  1  with out_valid: last result of frame.
out_sat  out  1  with out_valid: result was clamped (low or high).

Behaviour:
- Reset (rst=0, async): all outputs 0; row/col counters 0; shadow and active coefficients 0; line buffers and window registers 0. Holds for any state, including mid-frame.
- Stall: all counters, line buffers and window registers advance only on accepted pixels. in_valid=0 freezes state; out_valid deasserts the next cycle.
- Counters: accepted pixel gets position (row,col). col wraps LINE_LEN-1 -> 0 with row+1; row wraps NUM_ROWS-1 -> 0, i.e. an implicit new frame. An accepted in_sof forces the position to (0,0) regardless of counters; mid-frame sof abandons the current frame with no eof.
- Result: on acceptance of pixel (r,c) with r>=2 and c>=2, compute S = sum over i,j in 0..2 of w[3i+j]*x(r-2+i, c-2+j).
  - Pixels are zero-extended to signed; products and S are signed at ACC_W.
  - Latency 1: out_valid=1 on the clk edge following the accepting edge; otherwise out_valid=0.
  - Windows never span rows. Each frame produces (LINE_LEN-2)*(NUM_ROWS-2) results.
- Clamp: S<0 -> 0, out_sat=1. S>2^DATA_W-1 -> 2^DATA_W-1, out_sat=1. Otherwise out_data=S[DATA_W-1:0], out_sat=0.
- Markers: out_sof=1 for window (2,2); out_eof=1 for window (NUM_ROWS-1,LINE_LEN-1). Both are 0 when out_valid=0.
- Output registers: out_data/out_sat hold their last value while out_valid=0.
- Coefficients:
  - coef_we with coef_addr<=8 writes the shadow bank. coef_addr>8 is ignored.
  - The active bank loads from the shadow bank on an accepted pixel with position (0,0), whether from sof or wrap. That pixel's frame uses the new bank.
  - Simultaneous coef_we and commit: commit copies the pre-write shadow value; the write lands in shadow for the next frame.
  - Shadow writes never alter the frame in progress.
- Line buffers: two LINE_LEN-deep buffers advance on accepted pixels only. Contents from a previous or abandoned frame are never used for output, since results are gated on r>=2.

Test Plan:
- Setup for all tests unless noted: LINE_LEN=4, NUM_ROWS=4, x(r,c)=4r+c, sof on first pixel.
- Identity (w4=1, rest 0), no stalls -> out_data 5,6,9,10; out_sof on the first result, out_eof on the fourth, out_sat=0, exactly 4 out_valid pulses.
- All w=1, random in_valid gaps (about 50% duty) -> 45,54,81,90, each 1 cycle after the accepting edge; no out_valid while stalled.
- Saturation:
  - w4=-1, rest 0 -> four results of 0 with out_sat=1.
  - All w=1 with every pixel 0xFFFF -> 0xFFFF with out_sat=1.
- Coefficient timing: program identity, start frame A, and mid-frame A write all w=1 -> frame A gives 5,6,9,10; frame B (next sof, same data) gives 45,54,81,90. Also write coef_addr=9 -> no effect on any result.
- Reset and abort cases:
  - Drive rst=0 for one cycle at pixel (2,3) -> all outputs 0 immediately, coefficients 0.
  - After reprogramming identity and sending a fresh sof frame -> 5,6,9,10.
  - Mid-frame in_sof at (3,1) -> counters restart; no eof for the aborted frame.

Source files
------------

// File: rtl/conv3x3_stream_pipeline.sv
// Streaming 3x3 "valid"-mode convolution with two line buffers, a shadow/active
// coefficient bank committed at frame start, and clamped outputs with frame markers.
module conv3x3_stream_pipeline #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned COEF_W   = 17,
    parameter int unsigned LINE_LEN = 4,
    parameter int unsigned NUM_ROWS = 4,
    parameter int unsigned ACC_W    = DATA_W + COEF_W + 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_data,
    input  logic              coef_we,
    input  logic [3:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eof,
    output logic              out_sat
);

    localparam int unsigned COL_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int unsigned ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned NTAP  = 9;

    logic [COL_W-1:0] col_q, col_d, pos_col;
    logic [ROW_W-1:0] row_q, row_d, pos_row;

    logic [COEF_W-1:0] shadow_q [NTAP];
    logic [COEF_W-1:0] active_q [NTAP];

    logic [DATA_W-1:0] lb1_q [LINE_LEN];
    logic [DATA_W-1:0] lb2_q [LINE_LEN];
    logic [DATA_W-1:0] win_q [3][2];

    logic              out_valid_q, out_sof_q, out_eof_q, out_sat_q;
    logic [DATA_W-1:0] out_data_q;

    logic              commit, emit, sof_hit, eof_hit;
    logic [DATA_W-1:0] col_new [3];
    logic [DATA_W-1:0] tap [NTAP];
    logic [ACC_W-1:0]  sum;
    logic [DATA_W-1:0] clamp_data;
    logic              clamp_sat;

    // Position of the pixel on the input bus; an accepted sof overrides the counters.
    always_comb begin
        pos_col = in_sof ? '0 : col_q;
        pos_row = in_sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (in_valid) begin
            if (pos_col == COL_W'(LINE_LEN - 1)) begin
                col_d = '0;
                row_d = (pos_row == ROW_W'(NUM_ROWS - 1)) ? '0 : pos_row + ROW_W'(1);
            end else begin
                col_d = pos_col + COL_W'(1);
                row_d = pos_row;
            end
        end
    end

    always_comb begin
        commit  = in_valid && (pos_col == '0) && (pos_row == '0);
        emit    = in_valid && (pos_row >= ROW_W'(2)) && (pos_col >= COL_W'(2));
        sof_hit = (pos_row == ROW_W'(2)) && (pos_col == COL_W'(2));
        eof_hit = (pos_row == ROW_W'(NUM_ROWS - 1)) && (pos_col == COL_W'(LINE_LEN - 1));
    end

    // Column entering the window: rows r-2, r-1 from the line buffers, row r live.
    always_comb begin
        col_new[0] = lb2_q[LINE_LEN-1];
        col_new[1] = lb1_q[LINE_LEN-1];
        col_new[2] = in_data;
        for (int i = 0; i < 3; i++) begin
            tap[3*i]     = win_q[i][0];
            tap[3*i + 1] = win_q[i][1];
            tap[3*i + 2] = col_new[i];
        end
    end

    // Signed MAC: pixels zero-extended, coefficients sign-extended to ACC_W.
    always_comb begin
        sum = '0;
        for (int k = 0; k < NTAP; k++) begin
            sum = ACC_W'($signed({{(ACC_W-DATA_W){1'b0}}, tap[k]})
                       * $signed({{(ACC_W-COEF_W){active_q[k][COEF_W-1]}}, active_q[k]})
                       + $signed(sum));
        end
    end

    always_comb begin
        clamp_data = sum[DATA_W-1:0];
        clamp_sat  = 1'b0;
        if (sum[ACC_W-1]) begin
            clamp_data = '0;
            clamp_sat  = 1'b1;
        end else if (|sum[ACC_W-2:DATA_W]) begin
            clamp_data = '1;
            clamp_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Commit reads the pre-write shadow value, so a coincident write lands for the next frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NTAP; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            if (coef_we && (coef_addr <= 4'd8)) begin
                shadow_q[coef_addr] <= coef_data;
            end
            if (commit) begin
                for (int k = 0; k < NTAP; k++) begin
                    active_q[k] <= shadow_q[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < LINE_LEN; k++) begin
                lb1_q[k] <= '0;
                lb2_q[k] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                win_q[i][0] <= '0;
                win_q[i][1] <= '0;
            end
        end else if (in_valid) begin
            lb1_q[0] <= in_data;
            lb2_q[0] <= lb1_q[LINE_LEN-1];
            for (int k = 1; k < LINE_LEN; k++) begin
                lb1_q[k] <= lb1_q[k-1];
                lb2_q[k] <= lb2_q[k-1];
            end
            for (int i = 0; i < 3; i++) begin
                win_q[i][0] <= win_q[i][1];
                win_q[i][1] <= col_new[i];
            end
        end
    end

    // Data and sat hold between strobes; markers are qualified by the strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_sat_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= emit;
            out_sof_q   <= emit && sof_hit;
            out_eof_q   <= emit && eof_hit;
            if (emit) begin
                out_data_q <= clamp_data;
                out_sat_q  <= clamp_sat;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign out_sat   = out_sat_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_conv3x3_stream_pipeline.sv
// Directed bench for conv3x3_stream_pipeline on a 4x4 frame with x(r,c)=4r+c.
module tb_conv3x3_stream_pipeline;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_sof;
    logic [15:0] in_data;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [16:0] coef_data;
    logic        out_valid, out_sof, out_eof, out_sat;
    logic [15:0] out_data;

    int nchk = 0;
    int nerr = 0;
    logic [15:0] last_d = 16'd0;
    logic        last_sat = 1'b0;

    conv3x3_stream_pipeline dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wcoef(input int a, input int d);
        coef_we   = 1'b1;
        coef_addr = 4'(a);
        coef_data = 17'(d);
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic set_all(input int d);
        for (int k = 0; k < 9; k++) wcoef(k, d);
    endtask

    task automatic idle_check(input string tag);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        tick();
        chk({tag, " idle valid"}, 32'(out_valid), 32'd0);
        chk({tag, " idle hold data"}, 32'(out_data), 32'(last_d));
        chk({tag, " idle hold sat"}, 32'(out_sat), 32'(last_sat));
    endtask

    // Streams pixels k0..npix-1 of a 4x4 frame and checks every output cycle.
    task automatic run_frame(input bit sof, input bit stall, input bit ff, input int k0,
                             input int npix, input int e0, input int e1, input int e2,
                             input int e3, input bit esat, input string tag);
        int  exp_r [4];
        int  r, c;
        bit  emit;
        exp_r = '{e0, e1, e2, e3};
        for (int k = k0; k < npix; k++) begin
            r = k / 4;
            c = k % 4;
            for (int g = 0; g < 3 && stall && ($urandom_range(0, 1) == 1); g++) begin
                idle_check(tag);
            end
            in_valid = 1'b1;
            in_sof   = sof && (k == k0);
            in_data  = ff ? 16'hFFFF : 16'(4 * r + c);
            tick();
            in_valid = 1'b0;
            in_sof   = 1'b0;
            coef_we  = 1'b0;
            emit = (r >= 2) && (c >= 2);
            chk($sformatf("%s valid px%0d", tag, k), 32'(out_valid), 32'(emit));
            chk($sformatf("%s eof px%0d", tag, k), 32'(out_eof), 32'(emit && r == 3 && c == 3));
            if (emit) begin
                chk($sformatf("%s data px%0d", tag, k), 32'(out_data), 32'(exp_r[(r-2)*2 + c-2]));
                chk($sformatf("%s sof px%0d", tag, k), 32'(out_sof), 32'(r == 2 && c == 2));
                chk($sformatf("%s sat px%0d", tag, k), 32'(out_sat), 32'(esat));
                last_d   = 16'(exp_r[(r-2)*2 + c-2]);
                last_sat = esat;
            end else begin
                chk($sformatf("%s sof px%0d", tag, k), 32'(out_sof), 32'd0);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        tick();
        chk("reset valid", 32'(out_valid), 32'd0);
        chk("reset data", 32'(out_data), 32'd0);
        chk("reset sat", 32'(out_sat), 32'd0);
        chk("reset sof", 32'(out_sof), 32'd0);
        chk("reset eof", 32'(out_eof), 32'd0);
        rst = 1'b1;
        tick();

        wcoef(4, 1);
        run_frame(1, 0, 0, 0, 16, 5, 6, 9, 10, 0, "identity");
        idle_check("identity");

        set_all(1);
        run_frame(1, 1, 0, 0, 16, 45, 54, 81, 90, 0, "ones_stall");
        idle_check("ones_stall");

        set_all(0);
        wcoef(4, -1);
        run_frame(1, 0, 0, 0, 16, 0, 0, 0, 0, 1, "sat_low");

        set_all(1);
        run_frame(1, 0, 1, 0, 16, 65535, 65535, 65535, 65535, 1, "sat_high");

        // Frame A identity with mid-frame shadow writes; B commits via sof, C via wrap.
        set_all(0);
        wcoef(4, 1);
        run_frame(1, 0, 0, 0, 6, 5, 6, 9, 10, 0, "frameA");
        set_all(1);
        wcoef(9, 1000);
        run_frame(0, 0, 0, 6, 16, 5, 6, 9, 10, 0, "frameA");
        coef_we = 1'b1; coef_addr = 4'd4; coef_data = 17'd0;
        run_frame(1, 0, 0, 0, 16, 45, 54, 81, 90, 0, "frameB");
        run_frame(0, 0, 0, 0, 16, 40, 48, 72, 80, 0, "frameC_wrap");

        // Async reset while pixel (2,3) is on the bus.
        wcoef(4, 1);
        run_frame(1, 0, 0, 0, 11, 45, 54, 81, 90, 0, "pre_reset");
        in_valid = 1'b1; in_data = 16'd11;
        rst = 1'b0;
        #1;
        chk("async rst valid", 32'(out_valid), 32'd0);
        chk("async rst data", 32'(out_data), 32'd0);
        chk("async rst sof", 32'(out_sof), 32'd0);
        chk("async rst sat", 32'(out_sat), 32'd0);
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        last_d = 16'd0;
        last_sat = 1'b0;
        tick();
        run_frame(1, 0, 0, 0, 16, 0, 0, 0, 0, 0, "zero_coef");

        wcoef(4, 1);
        run_frame(1, 0, 0, 0, 16, 5, 6, 9, 10, 0, "post_reset");

        // Abort at (3,1) with a new sof; restart must yield a normal frame.
        run_frame(1, 0, 0, 0, 13, 5, 6, 9, 10, 0, "aborted");
        run_frame(1, 0, 0, 0, 16, 5, 6, 9, 10, 0, "restart");
        idle_check("restart");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
